// File: rtl/rom_arb_pkg.sv
// Shared constants and FSM encoding for arbiters that front the 8x8 ROM.
package rom_arb_pkg;

    localparam int ROM_AW      = 3;
    localparam int ROM_DW      = 8;
    localparam int ROM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr+1
// (ascending, wrapping) wins. A search that finds nothing returns zero outputs.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx
);

    logic [PW:0] pos_s;
    logic        found_s;

    // scan the rotated request vector for the first set bit
    always_comb begin
        win     = '0;
        win_idx = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s = {1'b0, ptr} + (PW+1)'(k) + (PW+1)'(1);
            if (pos_s >= (PW+1)'(NREQ)) begin
                pos_s = pos_s - (PW+1)'(NREQ);
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[pos_s[PW-1:0]]) begin
                found_s                = 1'b1;
                win[pos_s[PW-1:0]]     = 1'b1;
                win_idx                = pos_s[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin sequencer sharing the single ROM read port among NREQ requesters:
// grant, one-cycle rd pulse, wait out the ROM latency, one-cycle response pulse.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = ROM_AW,
    parameter int DW      = ROM_DW,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              busy,
    output logic              rom_rd,
    output logic [AW-1:0]     rom_add,
    input  logic [DW-1:0]     rom_data
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = 3;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            busy_q, busy_d;
    logic            rom_rd_q, rom_rd_d;
    logic [AW-1:0]   rom_add_q, rom_add_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] win_s;
    logic [PW-1:0]   win_idx_s;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win_s),
        .win_idx (win_idx_s)
    );

    // next-state and next-output logic for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rom_rd_d    = 1'b0;
        rom_add_d   = rom_add_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d   = S_ISSUE;
                    gnt_d     = win_s;
                    owner_d   = win_idx_s;
                    rom_add_d = req_addr[win_idx_s*AW +: AW];
                    rom_rd_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CW'(ROM_LAT);
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // count reaching one means the ROM output is valid at this edge
                if (cnt_q == 3'd1) begin
                    rsp_data_d  = rom_data;
                    rsp_valid_d = gnt_q;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                ptr_d   = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // state and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_add_q   <= '0;
            ptr_q       <= PW'(NREQ-1);
            owner_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            rom_rd_q    <= rom_rd_d;
            rom_add_q   <= rom_add_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign rom_rd    = rom_rd_q;
    assign rom_add   = rom_add_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter with a one-cycle-latency ROM model
// preloaded with mem[i] = 8'hA0 + i.
module tb_rom_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        rom_rd;
    logic [2:0]  rom_add;
    logic [7:0]  rom_data;
    logic [7:0]  mem [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] addr;
        logic [3:0]  gnt;
        logic        rd;
        logic [2:0]  add;
        logic [3:0]  vld;
        logic [7:0]  data;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    rom_rr_arbiter #(.NREQ(4), .AW(3), .DW(8), .ROM_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .rom_rd    (rom_rd),
        .rom_add   (rom_add),
        .rom_data  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
        rom_data = 8'h00;
    end

    always @(posedge clk) begin
        if (rom_rd) rom_data <= mem[rom_add];
    end

    function automatic logic [11:0] mk_addr(input logic [2:0] a0, input logic [2:0] a1,
                                            input logic [2:0] a2, input logic [2:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic [3:0] r, input logic [11:0] a, input logic [3:0] g,
                         input logic rd, input logic [2:0] ad, input logic [3:0] v,
                         input logic [7:0] d, input logic b);
        vec_t x;
        x.req = r; x.addr = a; x.gnt = g; x.rd = rd; x.add = ad;
        x.vld = v; x.data = d; x.busy = b;
        vecs.push_back(x);
    endtask

    initial begin
        logic [11:0] a_c, a_f, a_s;
        a_c = mk_addr(3'd4, 3'd5, 3'd6, 3'd7);
        a_f = mk_addr(3'd1, 3'd0, 3'd0, 3'd2);
        a_s = mk_addr(3'd0, 3'd0, 3'd7, 3'd0);

        // full contention: served 0,1,2,3, each dropping req after its pulse
        add_v(4'b1111, a_c, 4'b0001, 1'b1, 3'd4, 4'b0000, 8'h00, 1'b1);
        add_v(4'b1111, a_c, 4'b0001, 1'b0, 3'd0, 4'b0000, 8'h00, 1'b1);
        add_v(4'b1111, a_c, 4'b0001, 1'b0, 3'd0, 4'b0001, 8'hA4, 1'b1);
        add_v(4'b1110, a_c, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA4, 1'b0);
        add_v(4'b1110, a_c, 4'b0010, 1'b1, 3'd5, 4'b0000, 8'hA4, 1'b1);
        add_v(4'b1110, a_c, 4'b0010, 1'b0, 3'd0, 4'b0000, 8'hA4, 1'b1);
        add_v(4'b1110, a_c, 4'b0010, 1'b0, 3'd0, 4'b0010, 8'hA5, 1'b1);
        add_v(4'b1100, a_c, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA5, 1'b0);
        add_v(4'b1100, a_c, 4'b0100, 1'b1, 3'd6, 4'b0000, 8'hA5, 1'b1);
        add_v(4'b1100, a_c, 4'b0100, 1'b0, 3'd0, 4'b0000, 8'hA5, 1'b1);
        add_v(4'b1100, a_c, 4'b0100, 1'b0, 3'd0, 4'b0100, 8'hA6, 1'b1);
        add_v(4'b1000, a_c, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA6, 1'b0);
        add_v(4'b1000, a_c, 4'b1000, 1'b1, 3'd7, 4'b0000, 8'hA6, 1'b1);
        add_v(4'b1000, a_c, 4'b1000, 1'b0, 3'd0, 4'b0000, 8'hA6, 1'b1);
        add_v(4'b1000, a_c, 4'b1000, 1'b0, 3'd0, 4'b1000, 8'hA7, 1'b1);
        add_v(4'b0000, a_c, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA7, 1'b0);
        // wrap-around: 3 served last, so 0 beats 3
        add_v(4'b1001, a_f, 4'b0001, 1'b1, 3'd1, 4'b0000, 8'hA7, 1'b1);
        add_v(4'b1001, a_f, 4'b0001, 1'b0, 3'd0, 4'b0000, 8'hA7, 1'b1);
        add_v(4'b1001, a_f, 4'b0001, 1'b0, 3'd0, 4'b0001, 8'hA1, 1'b1);
        add_v(4'b1000, a_f, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA1, 1'b0);
        add_v(4'b1000, a_f, 4'b1000, 1'b1, 3'd2, 4'b0000, 8'hA1, 1'b1);
        add_v(4'b1000, a_f, 4'b1000, 1'b0, 3'd0, 4'b0000, 8'hA1, 1'b1);
        add_v(4'b1000, a_f, 4'b1000, 1'b0, 3'd0, 4'b1000, 8'hA2, 1'b1);
        add_v(4'b0000, a_f, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA2, 1'b0);
        // single read from requester 2 at address 7
        add_v(4'b0100, a_s, 4'b0100, 1'b1, 3'd7, 4'b0000, 8'hA2, 1'b1);
        add_v(4'b0100, a_s, 4'b0100, 1'b0, 3'd0, 4'b0000, 8'hA2, 1'b1);
        add_v(4'b0100, a_s, 4'b0100, 1'b0, 3'd0, 4'b0100, 8'hA7, 1'b1);
        add_v(4'b0000, a_s, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA7, 1'b0);
        add_v(4'b0000, a_s, 4'b0000, 1'b0, 3'd0, 4'b0000, 8'hA7, 1'b0);

        rst_n    = 1'b0;
        req      = 4'b0000;
        req_addr = 12'h000;
        #12;
        chk("reset_outputs", {11'd0, gnt, rsp_valid, rsp_data, busy, rom_rd, rom_add}, 32'd0);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_cycle%0d", i), {29'd0, rom_rd, busy, |gnt}, 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].req;
            req_addr = vecs[i].addr;
            step();
            chk($sformatf("vec%0d_outputs", i),
                {14'd0, gnt, rom_rd, rsp_valid, busy, rsp_data},
                {14'd0, vecs[i].gnt, vecs[i].rd, vecs[i].vld, vecs[i].busy, vecs[i].data});
            if (vecs[i].rd) chk($sformatf("vec%0d_rom_add", i), {29'd0, rom_add}, {29'd0, vecs[i].add});
        end

        // requester 2 drops during WAIT; requester 1 withdraws before any grant
        req      = 4'b0100;
        req_addr = mk_addr(3'd0, 3'd3, 3'd5, 3'd0);
        step();
        chk("late_drop_grant", {27'd0, gnt, rom_rd}, {27'd0, 4'b0100, 1'b1});
        req = 4'b0110;
        step();
        chk("late_drop_hold", {27'd0, gnt, rom_rd}, {27'd0, 4'b0100, 1'b0});
        req = 4'b0010;
        step();
        chk("late_drop_resp", {20'd0, rsp_valid, rsp_data}, {20'd0, 4'b0100, 8'hA5});
        req = 4'b0000;
        step();
        chk("withdraw_idle", {27'd0, gnt, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("withdraw_never_granted%0d", i), {27'd0, gnt, rom_rd}, 32'd0);
        end

        // reset asserted during WAIT aborts the transaction
        req      = 4'b0001;
        req_addr = mk_addr(3'd6, 3'd0, 3'd0, 3'd0);
        step();
        chk("midrst_grant", {28'd0, gnt}, {28'd0, 4'b0001});
        step();
        chk("midrst_wait", {27'd0, gnt, rom_rd, busy} & 32'h3F, {26'd0, 4'b0001, 1'b0, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {22'd0, gnt, rsp_valid, rom_rd, busy}, 32'd0);
        req = 4'b0000;
        step();
        chk("midrst_no_rsp", {20'd0, rsp_valid, rsp_data}, 32'd0);
        #2;
        rst_n = 1'b1;

        // pointer back at NREQ-1: requester 0 beats 3
        req      = 4'b1001;
        req_addr = mk_addr(3'd3, 3'd0, 3'd0, 3'd1);
        step();
        chk("post_rst_grant", {24'd0, gnt, rom_rd, rom_add}, {24'd0, 4'b0001, 1'b1, 3'd3});
        step();
        step();
        chk("post_rst_resp", {20'd0, rsp_valid, rsp_data}, {20'd0, 4'b0001, 8'hA3});
        req = 4'b1000;
        step();
        chk("post_rst_done", {27'd0, gnt, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_rr_arbiter.md
# rom_rr_arbiter

Round-robin arbiter and sequencer that shares the single synchronous read port of the 8×8 `rom` block among `NREQ` requesters. Each requester presents a level request with an address. The arbiter grants one requester at a time, drives `rom.rd`/`rom.add`, waits out the ROM read latency, and returns the data with a one-cycle valid pulse. It sits between client logic and `rom`, and is the only master of the ROM port.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 3: ROM address width.
- `DW`, 8: ROM data width.
- `ROM_LAT`, 1: ROM clock edges from sampling `rd` to valid `data_out`, 1..4.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input NREQ: per-requester level request.
- `req_addr` input NREQ*AW: flat addresses; requester i uses bits [i*AW +: AW].
- `gnt` output NREQ: one-hot owner of the current transaction; all-zero when idle.
- `rsp_valid` output NREQ: one-cycle pulse on the owner's bit when `rsp_data` is valid.
- `rsp_data` output DW: read data; holds its value until the next response.
- `busy` output 1: high whenever state ≠ IDLE.
- `rom_rd` output 1: to `rom.rd`.
- `rom_add` output AW: to `rom.add`.
- `rom_data` input DW: from `rom.data_out`.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If `req` ≠ 0, pick the winner with the round-robin rule.
  - Register `gnt`, `rom_add` = the winner's address, and `rom_rd`=1; go to ISSUE.
  - If `req` = 0, stay in IDLE.
- **ISSUE**
  - `rom_rd`=1 for exactly this cycle; the ROM samples at the end-of-cycle edge.
  - Clear `rom_rd`, load `cnt`=ROM_LAT, and go to WAIT.
- **WAIT**
  - Decrement `cnt` on each edge.
  - On the edge where `cnt`==1: `rsp_data`←`rom_data`, set `rsp_valid`[owner]=1, and go to RESP.
- **RESP**
  - `rsp_valid` is high for this cycle only.
  - On the exit edge: clear `rsp_valid` and `gnt`, set `ptr`=owner, and go to IDLE.
- **Round-robin rule**
  - Search starts at index (`ptr`+1) mod NREQ and ascends with wrap-around; the first set `req` bit wins.
  - `ptr` resets to NREQ-1, so requester 0 wins the first contention.
- **Requester protocol**
  - Hold `req` and `req_addr` stable until its `rsp_valid` pulse, then drop `req` within one cycle. Otherwise it is re-arbitrated as a new request.
  - Dropping `req` before grant withdraws the request.
  - Dropping `req` after grant is ignored: the response is still delivered.
- `rom_add` is held from ISSUE until the next grant; it is only meaningful while `rom_rd`=1.
- Requests arriving in ISSUE, WAIT or RESP wait; there is no queueing beyond the `req` level.

## Timing
- **Reset values**
  - State=IDLE, `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - `rom_rd`=0, `rom_add`=0, `ptr`=NREQ-1, `cnt`=0.
- **Latency**
  - `req` sampled at edge E0 → `rom_rd` high in cycle E0..E1 → `rsp_valid` high after edge E(1+ROM_LAT).
  - With ROM_LAT=1 this is 3 cycles from request to response.
- **Throughput**: one transaction every ROM_LAT+3 cycles; back-to-back grants have one IDLE cycle between them.
- **Simultaneous events**: all requesters asserting in the same cycle are served in rotating order with no starvation. Each waits at most (NREQ-1)×(ROM_LAT+3) cycles after its turn opens.
- **Reset mid-operation**: `rst_n` low in any state aborts the transaction immediately.
  - No `rsp_valid` is produced.
  - `rom_rd` drops asynchronously.
  - `ptr` returns to NREQ-1.
- Outputs are registered; no combinational path from `req` to any output.

## Structure
- Shared package/include `rom_arb_pkg`:
  - state encodings `S_IDLE`/`S_ISSUE`/`S_WAIT`/`S_RESP` (2-bit);
  - the `ROM_LAT` default;
  - the ROM geometry constants (AW=3, DW=8).
- Sub-module `rr_pick`: combinational. Inputs `req`[NREQ] and `ptr`; outputs a one-hot `win` and an index `win_idx`. It is reused by later shared-resource arbiters.
- Top level contains the FSM, `cnt`, `ptr` and the output registers.

## Test plan
The bench ROM model is preloaded with mem[i]=8'hA0+i; ROM_LAT=1.
- **Reset**: `rst_n`=0 → all outputs 0 and `busy`=0. Release, hold `req`=0 for 10 cycles → state stays IDLE and `rom_rd` never pulses.
- **Single read**: `req`=4'b0100, addr2=3'd7 → `rom_rd` one pulse with `rom_add`=7; `gnt`=4'b0100; `rsp_valid`=4'b0100 three cycles after the request, with `rsp_data`=8'hA7.
- **Full contention**: `req`=4'b1111, addresses 4,5,6,7, each requester dropping `req` after its pulse → responses in order 0,1,2,3 with data A4,A5,A6,A7, spaced 4 cycles apart.
- **Fairness and wrap-around**: requester 3 was served last, then `req`=4'b1001 → requester 0 wins next, then requester 3.
- **Withdraw and late drop**:
  - Requester 1 drops `req` before grant → never granted.
  - Requester 2 drops `req` during WAIT → `rsp_valid`[2] still pulses with correct data.
- **Reset mid-transaction**: assert `rst_n`=0 during WAIT → no `rsp_valid`, `gnt`=0 and `rom_rd`=0 immediately. After release, a new request to addr 3 returns 8'hA3.
